// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-ported RAM with 1-cycle read latency.
// Tie policy: fixed data priority by default; define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WIDTH-1:0]      if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WIDTH-1:0]      d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_wren,
  input  logic [WIDTH-1:0]      mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner_d;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [WIDTH-1:0]      r_wdata;

  logic w_arb;
  logic w_any;
  logic w_pick_d;

  assign w_arb = (r_state == IDLE) || (r_state == RESP);
  assign w_any = if_req || d_req;

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  // On a tie the port that did not win the previous decision goes first.
  assign w_pick_d = d_req && (!if_req || !r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_arb && w_any) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  // Operands are captured at the grant decision so a requester may drop req during ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_d <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
    end else if (w_arb && w_any) begin
      r_owner_d <= w_pick_d;
      r_addr    <= w_pick_d ? d_addr : if_addr;
      r_we      <= w_pick_d && d_we;
      r_wdata   <= w_pick_d ? d_wdata : '0;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: each always_comb assigns defaults first so no path leaves a latch behind.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_any ? ACCESS : IDLE;
      ACCESS:  w_next = RESP;
      RESP:    w_next = w_any ? ACCESS : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    mem_wren  = 1'b0;
    case (r_state)
      ACCESS: begin
        if_gnt   = !r_owner_d;
        d_gnt    = r_owner_d;
        mem_wren = r_we;
      end
      RESP: begin
        if_rvalid = !r_owner_d;
        d_rvalid  = r_owner_d;
      end
      default: ;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle-latency RAM.
// Tie expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [WIDTH-1:0]      if_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [WIDTH-1:0]      d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [WIDTH-1:0]      d_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_wren;
  logic [WIDTH-1:0]      mem_rdata;

  logic [WIDTH-1:0] ram [0:(1<<ADDR_WIDTH)-1];

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered RAM: write and read both take effect at the rising edge.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_if_gnt"},    {31'd0, if_gnt},    32'd0);
    check({tag, "_d_gnt"},     {31'd0, d_gnt},     32'd0);
    check({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    check({tag, "_d_rvalid"},  {31'd0, d_rvalid},  32'd0);
    check({tag, "_wren"},      {31'd0, mem_wren},  32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic exp_d;

    for (int i = 0; i < (1<<ADDR_WIDTH); i++) ram[i] = 32'h0;
    ram[10'h004] = 32'h00500093;
    ram[10'h020] = 32'hA0000020;
    ram[10'h021] = 32'hA1000021;
    ram[10'h022] = 32'hA2000022;
    ram[10'h023] = 32'hA3000023;

    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    do_reset();
    check_quiet("rst");
    check("rst_addr",  {22'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata,         32'd0);

    // Fetch alone
    if_req = 1'b1; if_addr = 10'h004;
    tick();
    check("f_if_gnt", {31'd0, if_gnt},   32'd1);
    check("f_d_gnt",  {31'd0, d_gnt},    32'd0);
    check("f_wren",   {31'd0, mem_wren}, 32'd0);
    check("f_addr",   {22'd0, mem_addr}, 32'h004);
    if_req = 1'b0;
    tick();
    check("f_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("f_if_rdata",  if_rdata,           32'h00500093);
    check("f_d_rvalid",  {31'd0, d_rvalid},  32'd0);
    check("f_gnt_off",   {31'd0, if_gnt},    32'd0);
    tick();
    check_quiet("f_idle");

    // Store then load
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'hDEADBEEF;
    tick();
    check("st_d_gnt", {31'd0, d_gnt},    32'd1);
    check("st_wren",  {31'd0, mem_wren}, 32'd1);
    check("st_addr",  {22'd0, mem_addr}, 32'h010);
    check("st_wdata", mem_wdata,         32'hDEADBEEF);
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    tick();
    check("st_wren_off", {31'd0, mem_wren}, 32'd0);
    check("st_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("st_if_rv",    {31'd0, if_rvalid}, 32'd0);
    tick();
    check_quiet("st_idle");
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    tick();
    check("ld_d_gnt", {31'd0, d_gnt},    32'd1);
    check("ld_wren",  {31'd0, mem_wren}, 32'd0);
    d_req = 1'b0;
    tick();
    check("ld_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("ld_d_rdata",  d_rdata,           32'hDEADBEEF);
    tick();

    // Simultaneous requests, first tie after reset: data first, fetch two cycles later
    do_reset();
    if_req = 1'b1; if_addr = 10'h004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    tick();
    check("tie_d_gnt",  {31'd0, d_gnt},  32'd1);
    check("tie_if_gnt", {31'd0, if_gnt}, 32'd0);
    d_req = 1'b0;
    tick();
    check("tie_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("tie_d_rdata",  d_rdata,           32'hDEADBEEF);
    check("tie_no_gnt",   {31'd0, if_gnt},   32'd0);
    tick();
    check("tie_if_gnt2", {31'd0, if_gnt}, 32'd1);
    check("tie_d_gnt2",  {31'd0, d_gnt},  32'd0);
    if_req = 1'b0;
    tick();
    check("tie_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("tie_if_rdata",  if_rdata,           32'h00500093);
    tick();

    // Both requests held continuously over four grants
    do_reset();
    if_req = 1'b1; if_addr = 10'h004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2) == 0;
`else
      exp_d = 1'b1;
`endif
      tick();
      check($sformatf("hold%0d_d_gnt", k),  {31'd0, d_gnt},  {31'd0, exp_d});
      check($sformatf("hold%0d_if_gnt", k), {31'd0, if_gnt}, {31'd0, !exp_d});
      tick();
      check($sformatf("hold%0d_d_rv", k),  {31'd0, d_rvalid},  {31'd0, exp_d});
      check($sformatf("hold%0d_if_rv", k), {31'd0, if_rvalid}, {31'd0, !exp_d});
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    check_quiet("hold_idle");

    // Continuous fetch stream of four
    if_req = 1'b1; if_addr = 10'h020;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("str%0d_if_gnt", k), {31'd0, if_gnt},   32'd1);
      check($sformatf("str%0d_d_gnt", k),  {31'd0, d_gnt},    32'd0);
      check($sformatf("str%0d_addr", k),   {22'd0, mem_addr}, 32'h020 + k);
      if (k == 3) if_req = 1'b0;
      else        if_addr = 10'h020 + 10'(k + 1);
      tick();
      check($sformatf("str%0d_if_rv", k),    {31'd0, if_rvalid}, 32'd1);
      check($sformatf("str%0d_if_rdata", k), if_rdata,           {4'hA, 4'(k), 16'h0000, 8'h20 + 8'(k)});
      check($sformatf("str%0d_gnt_off", k),  {31'd0, if_gnt},    32'd0);
    end
    tick();
    check_quiet("str_idle");

    // Reset in the middle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h030; d_wdata = 32'h12345678;
    tick();
    check("rs_wren", {31'd0, mem_wren}, 32'd1);
    rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
    tick();
    check_quiet("rs_after");
    check("rs_addr",  {22'd0, mem_addr}, 32'd0);
    check("rs_wdata", mem_wdata,         32'd0);
    rst = 1'b0;
    tick();
    check_quiet("rs_idle");
    if_req = 1'b1; if_addr = 10'h004;
    tick();
    check("rs_f_gnt", {31'd0, if_gnt}, 32'd1);
    if_req = 1'b0;
    tick();
    check("rs_f_rv",    {31'd0, if_rvalid}, 32'd1);
    check("rs_f_rdata", if_rdata,           32'h00500093);
    check("rs_d_rv",    {31'd0, d_rvalid},  32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
